// File: rtl/x_in_pkg.sv
// Shared definitions for the switch-input conditioner: debounce state
// encoding and default synchronizer/debounce depths.
package x_in_pkg;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_CHECK  = 1'b1
  } db_state_e;

  localparam int SYNC_STAGES_DEF = 2;
  localparam int DB_CYCLES_DEF   = 4;

endpackage

// File: rtl/x_in_sync_chain.sv
// N-flop synchronizer for a single asynchronous level; only the last stage
// is exported so nothing downstream can see a possibly metastable flop.
module sync_chain
  import x_in_pkg::*;
#(
  parameter int   N       = SYNC_STAGES_DEF,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;
  logic [N-1:0] sync_d;

  assign sync_d = {sync_q[N-2:0], d_i};

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      sync_q <= {N{RST_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/x_in_conditioner.sv
// Raw switch input -> synchronized, debounced level plus one-cycle rise/fall
// strobes; feeds the sequence-detector FSM's x_i.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_STABLE | synchronized input agrees with x_o; nothing to qualify
// ST_CHECK  | input disagrees with x_o; counting consecutive mismatch cycles
module x_in_conditioner
  import x_in_pkg::*;
#(
  parameter int   SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int   DB_CYCLES   = DB_CYCLES_DEF,
  parameter int   CNT_W       = 3,
  parameter logic RST_VAL     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic raw_i,
  output logic x_o,
  output logic rise_o,
  output logic fall_o
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic s_q;

  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             x_q, x_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  sync_chain #(
    .N       (SYNC_STAGES),
    .RST_VAL (RST_VAL)
  ) u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (raw_i),
    .q_o   (s_q)
  );

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      x_q     <= RST_VAL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  // Any agreement during qualification drops back to ST_STABLE, so a later
  // mismatch always restarts the count at one.
  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    x_d     = x_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      ST_STABLE: begin
        if (s_q != x_q) begin
          state_d = ST_CHECK;
          cnt_d   = CNT_ONE;
        end
      end
      ST_CHECK: begin
        if (s_q == x_q) begin
          state_d = ST_STABLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_STABLE;
          x_d     = ~x_q;
          rise_d  = ~x_q;
          fall_d  = x_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_STABLE;
      end
    endcase
  end

  assign x_o    = x_q;
  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: tb/tb_x_in_conditioner.sv
// Randomized and directed checks of x_in_conditioner against a
// mismatch-run-length reference model.
module tb_x_in_conditioner;

  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int LAT  = SYNC + DB;

  logic clk_i = 1'b0;
  logic rst_i;
  logic raw_i;
  logic x_o, rise_o, fall_o;

  int n_vec = 0;
  int n_err = 0;

  // Reference: x flips once the synchronized input has disagreed with it on
  // DB consecutive clock edges; synchronized input = raw sampled SYNC edges ago.
  bit hist [SYNC];
  bit m_s;
  bit m_x    = 1'b0;
  bit m_rise = 1'b0;
  bit m_fall = 1'b0;
  int m_run  = 0;

  x_in_conditioner #(
    .SYNC_STAGES (SYNC),
    .DB_CYCLES   (DB),
    .CNT_W       (3),
    .RST_VAL     (1'b0)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .raw_i  (raw_i),
    .x_o    (x_o),
    .rise_o (rise_o),
    .fall_o (fall_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < SYNC; i++) hist[i] = 1'b0;
      m_x = 1'b0; m_run = 0; m_rise = 1'b0; m_fall = 1'b0;
    end else begin
      m_s = hist[SYNC-1];
      for (int i = SYNC - 1; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = raw_i;
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (m_s != m_x) begin
        m_run++;
        if (m_run == DB) begin
          m_x    = ~m_x;
          m_rise = m_x;
          m_fall = ~m_x;
          m_run  = 0;
        end
      end else begin
        m_run = 0;
      end
    end
  end

  task automatic test_reset();
    rst_i = 1'b0;
    raw_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    n_vec++;
    if ({x_o, rise_o, fall_o} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_state: got x/rise/fall=%b%b%b want 000", x_o, rise_o, fall_o);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      n_vec++;
      if ({x_o, rise_o, fall_o} !== {m_x, m_rise, m_fall}) begin
        n_err++;
        $display("FAIL reset_idle c%0d: got %b%b%b want %b%b%b", i, x_o, rise_o, fall_o, m_x, m_rise, m_fall);
      end
    end
  endtask

  task automatic test_clean_rise();
    int lat = 0;
    int rises = 0;
    raw_i = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk_i);
      n_vec++;
      if ({x_o, rise_o, fall_o} !== {m_x, m_rise, m_fall}) begin
        n_err++;
        $display("FAIL clean_rise_model c%0d: got %b%b%b want %b%b%b", k, x_o, rise_o, fall_o, m_x, m_rise, m_fall);
      end
      if (rise_o) begin
        rises++;
        if (lat == 0) lat = k;
      end
    end
    n_vec++;
    if (lat !== LAT || rises !== 1 || x_o !== 1'b1) begin
      n_err++;
      $display("FAIL clean_rise_latency: got lat=%0d rises=%0d x=%b want lat=%0d rises=1 x=1", lat, rises, x_o, LAT);
    end
  endtask

  task automatic test_clean_fall();
    int lat = 0;
    int falls = 0;
    int rises = 0;
    raw_i = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk_i);
      n_vec++;
      if ({x_o, rise_o, fall_o} !== {m_x, m_rise, m_fall}) begin
        n_err++;
        $display("FAIL clean_fall_model c%0d: got %b%b%b want %b%b%b", k, x_o, rise_o, fall_o, m_x, m_rise, m_fall);
      end
      if (rise_o) rises++;
      if (fall_o) begin
        falls++;
        if (lat == 0) lat = k;
      end
    end
    n_vec++;
    if (lat !== LAT || falls !== 1 || rises !== 0 || x_o !== 1'b0) begin
      n_err++;
      $display("FAIL clean_fall_latency: got lat=%0d falls=%0d rises=%0d x=%b want lat=%0d falls=1 rises=0 x=0", lat, falls, rises, x_o, LAT);
    end
  endtask

  task automatic test_glitch();
    int rises = 0;
    int highs = 0;
    for (int k = 0; k < 14; k++) begin
      raw_i = (k < 2) ? 1'b1 : 1'b0;
      @(negedge clk_i);
      n_vec++;
      if ({x_o, rise_o, fall_o} !== {m_x, m_rise, m_fall}) begin
        n_err++;
        $display("FAIL glitch_model c%0d: got %b%b%b want %b%b%b", k, x_o, rise_o, fall_o, m_x, m_rise, m_fall);
      end
      if (rise_o) rises++;
      if (x_o) highs++;
    end
    n_vec++;
    if (rises !== 0 || highs !== 0) begin
      n_err++;
      $display("FAIL glitch_reject: got rises=%0d x_high_cycles=%0d want 0 and 0", rises, highs);
    end
  endtask

  task automatic test_bounce();
    bit pat [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int rises = 0;
    int lat = 0;
    for (int k = 0; k < 16; k++) begin
      raw_i = (k < 5) ? pat[k] : 1'b1;
      @(negedge clk_i);
      n_vec++;
      if ({x_o, rise_o, fall_o} !== {m_x, m_rise, m_fall}) begin
        n_err++;
        $display("FAIL bounce_model c%0d: got %b%b%b want %b%b%b", k, x_o, rise_o, fall_o, m_x, m_rise, m_fall);
      end
      if (rise_o) begin
        rises++;
        if (lat == 0) lat = k - 3;
      end
    end
    n_vec++;
    if (rises !== 1 || lat !== LAT || x_o !== 1'b1) begin
      n_err++;
      $display("FAIL bounce_restart: got rises=%0d lat=%0d x=%b want rises=1 lat=%0d x=1", rises, lat, x_o, LAT);
    end
  endtask

  task automatic test_random();
    int hold = 0;
    for (int k = 0; k < 400; k++) begin
      if (hold == 0) begin
        raw_i = 1'($urandom_range(0, 1));
        hold  = $urandom_range(1, 8);
      end
      hold--;
      @(negedge clk_i);
      n_vec++;
      if ({x_o, rise_o, fall_o} !== {m_x, m_rise, m_fall}) begin
        n_err++;
        $display("FAIL random_model c%0d: got %b%b%b want %b%b%b", k, x_o, rise_o, fall_o, m_x, m_rise, m_fall);
      end
    end
    raw_i = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk_i);
      n_vec++;
      if ({x_o, rise_o, fall_o} !== {m_x, m_rise, m_fall}) begin
        n_err++;
        $display("FAIL random_settle c%0d: got %b%b%b want %b%b%b", k, x_o, rise_o, fall_o, m_x, m_rise, m_fall);
      end
    end
  endtask

  // Stretched FSM stimulus: x_o must reproduce the drive sequence, shifted by
  // the pipeline latency (observed at the LAT-th falling edge after a change).
  task automatic test_integration();
    bit lvl [9] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    bit drv [$];
    bit obs [$];
    bit exp_x;
    for (int l = 0; l < 9; l++) begin
      for (int c = 0; c < 8; c++) begin
        raw_i = lvl[l];
        drv.push_back(lvl[l]);
        @(negedge clk_i);
        obs.push_back(x_o);
      end
    end
    for (int i = 0; i < obs.size(); i++) begin
      exp_x = (i >= LAT - 1) ? drv[i-(LAT-1)] : 1'b0;
      n_vec++;
      if (obs[i] !== exp_x) begin
        n_err++;
        $display("FAIL integration_delay c%0d: got x=%b want %b", i, obs[i], exp_x);
      end
    end
  endtask

  task automatic test_reset_midrun();
    bit seen = 1'b0;
    raw_i = 1'b1;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk_i);
      if (x_o === 1'b1) seen = 1'b1;
    end
    n_vec++;
    if (!seen) begin
      n_err++;
      $display("FAIL midrun_wait: got x=%b want 1 within 20 cycles", x_o);
    end
    @(negedge clk_i);
    #2 rst_i = 1'b0;
    #1;
    n_vec++;
    if ({x_o, rise_o, fall_o} !== 3'b000) begin
      n_err++;
      $display("FAIL midrun_async_reset: got x/rise/fall=%b%b%b want 000", x_o, rise_o, fall_o);
    end
    @(negedge clk_i);
    n_vec++;
    if ({x_o, rise_o, fall_o} !== 3'b000) begin
      n_err++;
      $display("FAIL midrun_reset_hold: got %b%b%b want 000", x_o, rise_o, fall_o);
    end
    rst_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      n_vec++;
      if ({x_o, rise_o, fall_o} !== {m_x, m_rise, m_fall}) begin
        n_err++;
        $display("FAIL midrun_recover c%0d: got %b%b%b want %b%b%b", k, x_o, rise_o, fall_o, m_x, m_rise, m_fall);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clean_rise();
    test_clean_fall();
    test_glitch();
    test_bounce();
    test_clean_fall();
    test_random();
    test_integration();
    test_reset_midrun();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/x_in_conditioner.md
Name: x_in_conditioner

Overview:
- Upstream input stage for the 4-state sequence-detector FSM.
- Takes a raw, asynchronous, possibly bouncing switch level and produces a clean, clock-synchronous level `x_o`, which drives the FSM's `x_i` directly.
- Also produces single-cycle rise/fall strobes for edge-driven consumers.
- Removes metastability risk and glitch-induced false state transitions in the downstream FSM.

Parameters:
- SYNC_STAGES, 2, number of synchronizer flops (legal range >= 2).
- DB_CYCLES, 4, consecutive cycles the synchronized input must differ from `x_o` before `x_o` updates (legal range >= 2).
- CNT_W, 3, debounce counter width; must satisfy 2^CNT_W > DB_CYCLES.
- RST_VAL, 1'b0, reset value of the synchronizer chain and of `x_o`.

Ports:
- clk_i  input  1  single system clock; all state updates on rising edge.
- rst_i  input  1  asynchronous, active-low reset (0 = reset asserted).
- raw_i  input  1  raw asynchronous switch level.
- x_o    output 1  debounced, synchronized level; feeds downstream FSM `x_i`.
- rise_o output 1  one-cycle pulse when `x_o` goes 0->1.
- fall_o output 1  one-cycle pulse when `x_o` goes 1->0.

Behaviour:
- Reset (`rst_i`=0, asynchronous, any time):
  - all sync flops = RST_VAL; cnt = 0; state = STABLE.
  - `x_o` = RST_VAL; `rise_o` = `fall_o` = 0.
  - Reset takes effect immediately, not at the next edge. Deassertion is sampled at clock edges.
- Synchronizer:
  - `sync[0]` <= `raw_i`; `sync[k]` <= `sync[k-1]`.
  - `s_q` = `sync[SYNC_STAGES-1]`.
  - No other logic reads `raw_i` or intermediate sync stages.
- Debounce FSM, 2 states, all outputs registered:
  - STABLE:
    - if `s_q` != `x_o` -> CHECK, cnt <= 1.
    - else stay; cnt <= 0.
  - CHECK:
    - if `s_q` == `x_o` -> STABLE, cnt <= 0. This is glitch rejection: `x_o` unchanged, no strobe.
    - else if cnt == DB_CYCLES-1 -> `x_o` <= ~`x_o`, STABLE, cnt <= 0. Assert `rise_o` (new `x_o`=1) or `fall_o` (new `x_o`=0) in the same cycle `x_o` changes.
    - else cnt <= cnt+1.
- Strobes:
  - High for exactly one cycle; never both high together.
  - 0 in every cycle where `x_o` does not change.
- Latency:
  - `raw_i` change sampled at edge E1 and held -> `x_o` changes at edge E(SYNC_STAGES+DB_CYCLES).
  - Defaults: 6 edges.
- Glitch rejection:
  - A pulse on `s_q` shorter than DB_CYCLES cycles never reaches `x_o`.
  - A bounce during CHECK restarts qualification from STABLE. A later mismatch starts again at cnt=1 and does not resume the old count.
- Simultaneous events:
  - Reset dominates everything.
  - Mismatch ending on the same edge the count completes: evaluated on the registered `s_q` at that edge; no look-ahead.
- Reset mid-qualification: the count is discarded; `x_o` returns to RST_VAL even if it was 1.
- Counter never exceeds DB_CYCLES-1 and never wraps.

Decomposition:
- Shared package `x_in_pkg`:
  - state localparams: ST_STABLE=1'b0, ST_CHECK=1'b1.
  - defaults: SYNC_STAGES_DEF=2, DB_CYCLES_DEF=4.
- One sub-module, `sync_chain`: parameterized N-flop synchronizer with async active-low reset and reset value parameter.
- Debounce FSM, counter and strobe logic stay in `x_in_conditioner`.

Test Plan:
Clock period 10, rising edges at t=5, 15, 25, …; defaults unless stated.
1. Reset: `rst_i`=0 at t=0, released at t=2 -> `x_o`=0, `rise_o`=`fall_o`=0. Assert `rst_i`=0 mid-run while `x_o`=1 -> `x_o`=0 immediately, no strobe.
2. Clean rise: `raw_i` 0->1 at t=11, held -> `x_o`=1 and `rise_o`=1 for one cycle after edge t=65 (6th edge from t=15); `x_o` stays 1.
3. Glitch: `raw_i`=1 from t=11 to t=31 (2 samples) -> `x_o` stays 0; no `rise_o` ever.
4. Bounce: `raw_i` 1 for 3 cycles, 0 for 1 cycle, then 1 held -> `x_o` rises only 6 edges after the final 0->1 sample; exactly one `rise_o`.
5. Clean fall: from `x_o`=1, `raw_i`->0 held -> `x_o`=0 after 6 edges with a one-cycle `fall_o`; `rise_o` stays 0.
6. Integration: drive `x_o` into the FSM `x_i` with the bench's x sequence (0,1,1,0,1,0,…) stretched to at least 8 cycles per level -> the FSM state sequence matches the direct-drive run, delayed by 6 cycles.
